boot_image_loader: RTL

BOOT_IMAGE_LOADER -- requirements
Module: boot_image_loader

---
 rtl/boot_pkg.sv | 25 ++
 rtl/boot_csum_acc.sv | 24 ++
 rtl/boot_image_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot image loader: FSM encoding,
// default header magic and the fixed header word offsets.
package boot_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_MAGIC = 3'd1;
    localparam state_t ST_LEN   = 3'd2;
    localparam state_t ST_COPY  = 3'd3;
    localparam state_t ST_CHECK = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_ERROR = 3'd6;

    localparam logic [31:0] MAGIC_DEFAULT = 32'h5EC0B007;

    localparam int HDR_MAGIC   = 0;
    localparam int HDR_LEN     = 1;
    localparam int HDR_PAYLOAD = 2;

    function automatic logic state_is_busy(input state_t s);
        return (s == ST_MAGIC) || (s == ST_LEN) || (s == ST_COPY) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/boot_csum_acc.sv
// 32-bit wrap-around accumulator with synchronous clear and enable,
// used for the running payload checksum.
module boot_csum_acc (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [31:0] i_data,
    output logic [31:0] o_sum
);

    logic [31:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/boot_image_loader.sv
// Copies a {MAGIC, N, payload[N], checksum} image from boot ROM into RAM,
// then releases CPU reset. Define BOOT_LOADER_CHECKSUM_EN to enforce the checksum.
module boot_image_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] MAGIC  = MAGIC_DEFAULT,
    parameter int          ROM_AW = 10,
    parameter int          RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_rdata,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_rst_hold,
    output logic [31:0]       checksum,
    output state_t            dbg_state
);

    localparam logic [33:0] ROM_WORDS = 34'd1 << ROM_AW;
    localparam logic [33:0] RAM_WORDS = 34'd1 << RAM_AW;

    state_t            r_state;
    logic [ROM_AW-1:0] r_rom_addr;
    logic [RAM_AW-1:0] r_index;
    logic [RAM_AW-1:0] r_last_idx;

    logic [33:0] w_len_ext;
    logic        w_len_bad;
    logic        w_in_copy;
    logic        w_csum_clr;
    logic [31:0] w_csum;

    // Length is checked in 34 bits so N+3 cannot wrap for any 32-bit N.
    assign w_len_ext = {2'b00, rom_rdata};
    assign w_len_bad = (rom_rdata == 32'd0)
                    || ((w_len_ext + 34'd3) > ROM_WORDS)
                    || (w_len_ext > RAM_WORDS);

    assign w_in_copy  = (r_state == ST_COPY);
    assign w_csum_clr = (r_state == ST_IDLE) && start;

    boot_csum_acc u_csum (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_csum_clr),
        .i_en   (w_in_copy),
        .i_data (rom_rdata),
        .o_sum  (w_csum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rom_addr <= '0;
            r_index    <= '0;
            r_last_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_MAGIC;
                        r_rom_addr <= ROM_AW'(HDR_MAGIC);
                    end
                end
                ST_MAGIC: begin
                    if (rom_rdata == MAGIC) begin
                        r_state    <= ST_LEN;
                        r_rom_addr <= ROM_AW'(HDR_LEN);
                    end else begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_LEN: begin
                    if (w_len_bad) begin
                        r_state <= ST_ERROR;
                    end else begin
                        r_last_idx <= RAM_AW'(rom_rdata - 32'd1);
                        r_index    <= '0;
                        r_rom_addr <= ROM_AW'(HDR_PAYLOAD);
                        r_state    <= ST_COPY;
                    end
                end
                ST_COPY: begin
                    // Final increment leaves rom_addr on the trailing checksum word (N+2).
                    r_rom_addr <= r_rom_addr + 1'b1;
                    r_index    <= r_index + 1'b1;
                    if (r_index == r_last_idx) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    r_state <= (rom_rdata == w_csum) ? ST_DONE : ST_ERROR;
`else
                    r_state <= ST_DONE;
`endif
                end
                ST_DONE, ST_ERROR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr     = r_rom_addr;
    assign ram_we       = w_in_copy;
    assign ram_addr     = w_in_copy ? r_index : '0;
    assign ram_wdata    = w_in_copy ? rom_rdata : 32'd0;
    assign busy         = state_is_busy(r_state);
    assign done         = (r_state == ST_DONE);
    assign error        = (r_state == ST_ERROR);
    assign cpu_rst_hold = (r_state != ST_DONE);
    assign checksum     = w_csum;
    assign dbg_state    = r_state;

endmodule
